// File: rtl/alu_func_exec.sv
// EX-stage ALU: decodes alu_op/func, single-cycle ops plus iterative mult/div into HI/LO.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for mult/div; in_ready drops while iterating.
module alu_func_exec #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_ILL} kind_t;

    state_t state, state_nx;
    kind_t  kind;

    logic [WIDTH-1:0]   alu_res;
    logic               sgn, wr_hi, wr_lo;
    logic               a_neg, b_neg, div0;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplr, rem, dvsr;
    logic               neg_q, neg_r;
    logic [SHW-1:0]     cnt;
    logic               last;

    logic [2*WIDTH-1:0] acc_nx, prod;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nx, quo_nx, quo_f, rem_f;

    always_comb begin
        kind    = K_ALU;
        alu_res = '0;
        sgn     = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (alu_op)
            2'b00: alu_res = a + b;
            2'b01: alu_res = a - b;
            2'b10: begin
                case (func)
                    6'h20, 6'h21: alu_res = a + b;
                    6'h22, 6'h23: alu_res = a - b;
                    6'h24: alu_res = a & b;
                    6'h25: alu_res = a | b;
                    6'h26: alu_res = a ^ b;
                    6'h27: alu_res = ~(a | b);
                    6'h2a: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'h2b: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'h00: alu_res = b << shamt;
                    6'h02: alu_res = b >> shamt;
                    6'h03: alu_res = $signed(b) >>> shamt;
                    6'h04: alu_res = b << a[SHW-1:0];
                    6'h06: alu_res = b >> a[SHW-1:0];
                    6'h07: alu_res = $signed(b) >>> a[SHW-1:0];
                    6'h10: alu_res = hi;
                    6'h12: alu_res = lo;
                    6'h11: begin alu_res = a; wr_hi = 1'b1; end
                    6'h13: begin alu_res = a; wr_lo = 1'b1; end
                    6'h18: begin kind = K_MUL; sgn = 1'b1; end
                    6'h19: kind = K_MUL;
                    6'h1a: begin kind = K_DIV; sgn = 1'b1; end
                    6'h1b: kind = K_DIV;
                    default: kind = K_ILL;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

    // Iterative units work on magnitudes; signs are reapplied on the final step.
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign div0  = (b == '0);
    assign last  = (cnt == SHW'(WIDTH-1));

    assign acc_nx = acc + (mplr[0] ? mcand : '0);
    assign prod   = neg_q ? -acc_nx : acc_nx;

    // Restoring step: a set borrow bit means the trial subtraction went negative.
    assign trial  = {rem, mplr[WIDTH-1]} - {1'b0, dvsr};
    assign rem_nx = trial[WIDTH] ? {rem[WIDTH-2:0], mplr[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_nx = {mplr[WIDTH-2:0], ~trial[WIDTH]};
    assign quo_f  = neg_q ? -quo_nx : quo_nx;
    assign rem_f  = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) begin
                if (kind == K_MUL)               state_nx = S_MUL;
                else if (kind == K_DIV && !div0) state_nx = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            rem       <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    cnt <= '0;
                    case (kind)
                        K_ALU: begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= 1'b0;
                            if (wr_hi) hi <= a;
                            if (wr_lo) lo <= a;
                        end
                        K_ILL: begin
                            out_valid <= 1'b1;
                            result    <= '0;
                            zero      <= 1'b1;
                            illegal   <= 1'b1;
                        end
                        K_MUL: begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                            mplr  <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                        end
                        default: begin
                            if (div0) begin
                                out_valid <= 1'b1;
                                result    <= '1;
                                zero      <= 1'b0;
                                illegal   <= 1'b0;
                                lo        <= '1;
                                hi        <= a;
                            end else begin
                                rem   <= '0;
                                mplr  <= a_mag;
                                dvsr  <= b_mag;
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                            end
                        end
                    endcase
                end
                S_MUL: begin
                    acc   <= acc_nx;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + SHW'(1);
                    if (last) begin
                        out_valid <= 1'b1;
                        result    <= prod[WIDTH-1:0];
                        zero      <= (prod[WIDTH-1:0] == '0);
                        illegal   <= 1'b0;
                        hi        <= prod[2*WIDTH-1:WIDTH];
                        lo        <= prod[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    rem  <= rem_nx;
                    mplr <= quo_nx;
                    cnt  <= cnt + SHW'(1);
                    if (last) begin
                        out_valid <= 1'b1;
                        result    <= quo_f;
                        zero      <= (quo_f == '0);
                        illegal   <= 1'b0;
                        hi        <= rem_f;
                        lo        <= quo_f;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_func_exec.sv
// Scoreboard bench for alu_func_exec (WIDTH=32): directed cases plus randomized ops vs. a behavioural model.
module tb_alu_func_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    alu_op = '0;
    logic [5:0]    func = '0;
    logic [4:0]    shamt = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic          out_valid, zero, illegal;
    logic [W-1:0]  result, hi, lo;

    alu_func_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func(func), .shamt(shamt), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           icyc;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [W-1:0] mhi = '0, mlo = '0;

    logic [5:0] valid_funcs [24] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                     6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    initial forever @(posedge clk) cyc++;

    // Reference: computes the architectural outcome directly with wide arithmetic.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [W-1:0] x, input logic [W-1:0] y, output exp_t e);
        logic signed [63:0] sp, sx, sy, sq, sr;
        logic [63:0]        up;
        logic [W-1:0]       r;
        e.ill = 1'b0;
        e.lat = 0;
        r     = '0;
        sx    = $signed({{32{x[31]}}, x});
        sy    = $signed({{32{y[31]}}, y});
        if (op == 2'd0)      r = x + y;
        else if (op == 2'd1) r = x - y;
        else if (op == 2'd3) e.ill = 1'b1;
        else begin
            case (fn)
                6'h20, 6'h21: r = x + y;
                6'h22, 6'h23: r = x - y;
                6'h24: r = x & y;
                6'h25: r = x | y;
                6'h26: r = x ^ y;
                6'h27: r = ~(x | y);
                6'h2a: r = (sx < sy) ? 1 : 0;
                6'h2b: r = (x < y) ? 1 : 0;
                6'h00: r = y << sh;
                6'h02: r = y >> sh;
                6'h03: r = sy >>> sh;
                6'h04: r = y << (x % 32);
                6'h06: r = y >> (x % 32);
                6'h07: r = sy >>> (x % 32);
                6'h10: r = mhi;
                6'h12: r = mlo;
                6'h11: begin mhi = x; r = x; end
                6'h13: begin mlo = x; r = x; end
                6'h18: begin sp = sx * sy; {mhi, mlo} = sp; r = mlo; e.lat = 32; end
                6'h19: begin up = {32'b0, x} * {32'b0, y}; {mhi, mlo} = up; r = mlo; e.lat = 32; end
                6'h1a, 6'h1b: begin
                    if (y == 0) begin
                        mlo = '1; mhi = x;
                    end else if (fn == 6'h1a) begin
                        sq = sx / sy; sr = sx % sy;
                        mlo = sq[31:0]; mhi = sr[31:0]; e.lat = 32;
                    end else begin
                        mlo = x / y; mhi = x % y; e.lat = 32;
                    end
                    r = mlo;
                end
                default: e.ill = 1'b1;
            endcase
        end
        e.res  = e.ill ? '0 : r;
        e.zero = (e.res == 0);
        e.hi   = mhi;
        e.lo   = mlo;
    endtask

    // Called at a negedge; returns at the following negedge with in_valid dropped.
    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [W-1:0] x, input logic [W-1:0] y, input bit push, input exp_t e);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        alu_op = op; func = fn; shamt = sh; a = x; b = y;
        in_valid = 1'b1;
        e.icyc = cyc + 1;
        if (push) sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        model(op, fn, sh, x, y, e);
        drive(op, fn, sh, x, y, 1'b1, e);
    endtask

    task automatic issue_k(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] r, input logic [W-1:0] h, input logic [W-1:0] l, input int lat);
        exp_t e;
        e.res = r; e.zero = (r == 0); e.ill = 1'b0; e.hi = h; e.lo = l; e.lat = lat;
        mhi = h; mlo = l;
        drive(op, fn, sh, x, y, 1'b1, e);
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result",  result,  e.res);
                chk("zero",    zero,    e.zero);
                chk("illegal", illegal, e.ill);
                chk("hi",      hi,      e.hi);
                chk("lo",      lo,      e.lo);
                chk("latency", cyc - e.icyc, e.lat);
            end
        end
    end

    initial begin
        exp_t dummy;
        int   t;
        dummy = '{default: '0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hi",        hi,        0);
        chk("rst_lo",        lo,        0);
        chk("rst_result",    result,    0);
        chk("rst_zero",      zero,      0);
        chk("rst_illegal",   illegal,   0);

        // back-to-back single-cycle ops
        issue_k(2'b01, 6'h00, 5'd0, 32'd5,  32'd7,  32'hFFFFFFFE, mhi, mlo, 0);
        issue_k(2'b10, 6'h24, 5'd0, 32'hF0, 32'h3C, 32'h30,       mhi, mlo, 0);
        issue_k(2'b10, 6'h03, 5'd4, 32'd0,  32'h80000000, 32'hF8000000, mhi, mlo, 0);
        issue_k(2'b10, 6'h06, 5'd0, 32'd36, 32'h80000000, 32'h08000000, mhi, mlo, 0);
        issue_k(2'b10, 6'h2a, 5'd0, 32'hFFFFFFFF, 32'd0, 32'd1, mhi, mlo, 0);

        // mult with junk issue attempts while busy
        issue_k(2'b10, 6'h18, 5'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 32);
        for (int i = 0; i < 32; i++) begin
            chk("busy_in_ready", in_ready, 0);
            alu_op = 2'b10; func = 6'h11; a = $urandom; b = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done_in_ready", in_ready, 1);

        issue_k(2'b10, 6'h1a, 5'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32);
        issue_k(2'b10, 6'h1b, 5'd0, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 0);
        issue_k(2'b10, 6'h1a, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h80000000, 32);
        issue_k(2'b10, 6'h11, 5'd0, 32'h1234, 32'd0, 32'h1234, 32'h1234, mlo, 0);
        issue_k(2'b10, 6'h10, 5'd0, 32'd0, 32'd0, 32'h1234, 32'h1234, mlo, 0);

        for (int n = 0; n < 250; n++) begin
            logic [1:0]   op;
            logic [5:0]   fn;
            logic [W-1:0] x, y;
            int           r;
            r  = $urandom_range(0, 19);
            op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
            fn = ($urandom_range(0, 19) == 0) ? 6'($urandom) : valid_funcs[$urandom_range(0, 23)];
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 9))
                0: y = '0;
                1: begin x = 32'h80000000; y = '1; end
                2: begin x = $urandom_range(0, 20); y = $urandom_range(0, 20); end
                default: ;
            endcase
            issue_m(op, fn, 5'($urandom), x, y);
        end

        // reset while a multu is iterating: no completion, HI/LO cleared
        t = 0;
        while (sbq.size() != 0 && t < 200) begin @(negedge clk); t++; end
        drive(2'b10, 6'h19, 5'd0, 32'hDEADBEEF, 32'h12345, 1'b0, dummy);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mhi = '0; mlo = '0;
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_hi",        hi,        0);
        chk("midrst_lo",        lo,        0);

        issue_m(2'b10, 6'h3F, 5'd0, 32'd1, 32'd2);
        issue_m(2'b11, 6'h20, 5'd0, 32'd1, 32'd2);
        repeat (40) @(negedge clk);

        t = 0;
        while (sbq.size() != 0 && t < 200) begin @(negedge clk); t++; end
        chk("drain_outstanding", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
